// File: rtl/imem_line_responder.sv
// Memory-side line responder for the fetch-stage instruction-miss interface.
// Optional bounds checking is enabled with `define IMEM_BOUNDS_CHECK_EN.
module imem_line_responder #(
   parameter  int ADDR_W    = 20,
   parameter  int LINE_W    = 128,
   parameter  int MEM_LINES = 1024,
   parameter  int LATENCY   = 5,
   localparam int IDX_W     = $clog2(MEM_LINES)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic              i_data_filled_ack,
   input  logic              i_pl_we,
   input  logic [IDX_W-1:0]  i_pl_line,
   input  logic [LINE_W-1:0] i_pl_data,
   output logic [LINE_W-1:0] o_line_out,
   output logic              o_mem_data_rdy,
`ifdef IMEM_BOUNDS_CHECK_EN
   output logic              o_range_err,
`endif
   output logic              o_busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2,
      GAP  = 2'd3
   } state_t;

   localparam int       LA_W     = ADDR_W - 4;
   localparam bit       LAT_ONE  = (LATENCY == 1);
   localparam bit [7:0] LAT_M1   = 8'(LATENCY - 1);

   state_t            r_state;
   logic [7:0]        r_cnt;
   logic [IDX_W-1:0]  r_idx;
   logic [LINE_W-1:0] r_line;
   logic              r_rdy;
   logic              r_busy;
   logic [LINE_W-1:0] r_ram [MEM_LINES];

   logic [LA_W-1:0]   w_line_addr;
   logic [IDX_W-1:0]  w_idx;
   logic [IDX_W-1:0]  w_rd_idx;
   logic [LINE_W-1:0] w_rd_data;
   logic [LINE_W-1:0] w_resp_data;
   logic              w_go_resp;
   logic              w_unused;

   assign w_line_addr = i_req_addr[ADDR_W-1:4];
   assign w_idx       = w_line_addr[IDX_W-1:0];

   // Entering RESP straight from IDLE uses the live index (LATENCY==1)
   assign w_rd_idx  = (r_state == IDLE) ? w_idx : r_idx;
   assign w_rd_data = (i_pl_we && (i_pl_line == w_rd_idx)) ?
                      i_pl_data : r_ram[w_rd_idx];

   assign w_go_resp = ((r_state == IDLE) && i_req && LAT_ONE) ||
                      ((r_state == WAIT) && (r_cnt == 8'd0));

`ifdef IMEM_BOUNDS_CHECK_EN
   logic r_oor;
   logic r_range_err;
   logic w_oor;
   logic w_rd_oor;

   assign w_oor       = (64'(w_line_addr) >= 64'(MEM_LINES));
   assign w_rd_oor    = (r_state == IDLE) ? w_oor : r_oor;
   assign w_resp_data = w_rd_oor ? '0 : w_rd_data;
   assign o_range_err = r_range_err;
   assign w_unused    = ^i_req_addr[3:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_oor       <= 1'b0;
         r_range_err <= 1'b0;
      end else begin
         if ((r_state == IDLE) && i_req)
            r_oor <= w_oor;
         if (w_go_resp)
            r_range_err <= w_rd_oor;
         else if ((r_state == RESP) && i_data_filled_ack)
            r_range_err <= 1'b0;
      end
   end
`else
   assign w_resp_data = w_rd_data;
   assign w_unused    = ^{i_req_addr[3:0], w_line_addr};
`endif

   // Backing RAM is never cleared by reset
   always_ff @(posedge clk) begin
      if (i_pl_we)
         r_ram[i_pl_line] <= i_pl_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= 8'd0;
         r_idx   <= '0;
         r_line  <= '0;
         r_rdy   <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (i_req) begin
                  r_idx  <= w_idx;
                  r_busy <= 1'b1;
                  r_cnt  <= LAT_M1;
                  r_state <= LAT_ONE ? RESP : WAIT;
               end
            end
            WAIT: begin
               if (r_cnt == 8'd0)
                  r_state <= RESP;
               else
                  r_cnt <= r_cnt - 8'd1;
            end
            RESP: begin
               if (i_data_filled_ack) begin
                  r_rdy   <= 1'b0;
                  r_state <= GAP;
               end
            end
            GAP: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
         if (w_go_resp) begin
            r_line <= w_resp_data;
            r_rdy  <= 1'b1;
         end
      end
   end

   assign o_line_out     = r_line;
   assign o_mem_data_rdy = r_rdy;
   assign o_busy         = r_busy;

endmodule

// File: tb/tb_imem_line_responder.sv
// Directed self-checking bench for imem_line_responder.
// Covers latency, ack handshake, GAP, reset abort, preload ordering, wrap/bounds.
module tb_imem_line_responder;

   localparam logic [127:0] L3 = {16{8'hA5}};
   localparam logic [127:0] L0 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
   localparam logic [127:0] L7 = {16{8'h77}};
   localparam logic [127:0] L5 = {16{8'h55}};

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         req = 1'b0;
   logic [19:0]  addr = '0;
   logic         ack = 1'b0;
   logic         req1 = 1'b0;
   logic [19:0]  addr1 = '0;
   logic         ack1 = 1'b0;
   logic         pl_we = 1'b0;
   logic [9:0]   pl_line = '0;
   logic [127:0] pl_data = '0;
   logic [127:0] line_out;
   logic [127:0] line_out1;
   logic         rdy;
   logic         rdy1;
   logic         busy;
   logic         busy1;
`ifdef IMEM_BOUNDS_CHECK_EN
   logic         range_err;
   logic         range_err1;
`endif

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   imem_line_responder #(.LATENCY(5)) u_dut (
      .clk               (clk),
      .reset             (reset),
      .i_req             (req),
      .i_req_addr        (addr),
      .i_data_filled_ack (ack),
      .i_pl_we           (pl_we),
      .i_pl_line         (pl_line),
      .i_pl_data         (pl_data),
      .o_line_out        (line_out),
      .o_mem_data_rdy    (rdy),
`ifdef IMEM_BOUNDS_CHECK_EN
      .o_range_err       (range_err),
`endif
      .o_busy            (busy)
   );

   imem_line_responder #(.LATENCY(1)) u_dut1 (
      .clk               (clk),
      .reset             (reset),
      .i_req             (req1),
      .i_req_addr        (addr1),
      .i_data_filled_ack (ack1),
      .i_pl_we           (pl_we),
      .i_pl_line         (pl_line),
      .i_pl_data         (pl_data),
      .o_line_out        (line_out1),
      .o_mem_data_rdy    (rdy1),
`ifdef IMEM_BOUNDS_CHECK_EN
      .o_range_err       (range_err1),
`endif
      .o_busy            (busy1)
   );

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic preload(input logic [9:0] ln, input logic [127:0] d);
      pl_we = 1'b1;
      pl_line = ln;
      pl_data = d;
      step();
      pl_we = 1'b0;
   endtask

   task automatic issue(input logic [19:0] a);
      req = 1'b1;
      addr = a;
      step();
      req = 1'b0;
   endtask

   task automatic do_ack;
      ack = 1'b1;
      step();
      ack = 1'b0;
   endtask

   initial begin
      step(2);
      chk("rst_rdy", {127'd0, rdy}, 128'd0);
      chk("rst_line", line_out, 128'd0);
      chk("rst_busy", {127'd0, busy}, 128'd0);
`ifdef IMEM_BOUNDS_CHECK_EN
      chk("rst_rerr", {127'd0, range_err}, 128'd0);
`endif
      reset = 1'b0;
      preload(10'd3, L3);
      preload(10'd0, L0);
      preload(10'd7, L7);
      preload(10'd5, L5);

      // basic latency and ack
      issue(20'h00030);
      chk("t1_busy", {127'd0, busy}, 128'd1);
      step(4);
      chk("t1_rdy_e4", {127'd0, rdy}, 128'd0);
      step();
      chk("t1_rdy_e5", {127'd0, rdy}, 128'd1);
      chk("t1_line", line_out, L3);
`ifdef IMEM_BOUNDS_CHECK_EN
      chk("t1_rerr", {127'd0, range_err}, 128'd0);
`endif
      step(2);
      chk("t1_hold", {127'd0, rdy}, 128'd1);
      do_ack();
      chk("t1_ack_rdy", {127'd0, rdy}, 128'd0);
      chk("t1_ack_line", line_out, L3);

      // req held through GAP
      req = 1'b1;
      addr = 20'h00070;
      step();
      chk("t2_gap_idle", {127'd0, busy}, 128'd0);
      step();
      req = 1'b0;
      chk("t2_accept", {127'd0, busy}, 128'd1);
      step(4);
      chk("t2_rdy_a6", {127'd0, rdy}, 128'd0);
      step();
      chk("t2_rdy_a7", {127'd0, rdy}, 128'd1);
      chk("t2_line", line_out, L7);
      do_ack();
      step();

      // preload ordering
      issue(20'h00050);
      step();
      preload(10'd5, 128'h1234);
      step(2);
      chk("t5_rdy_e4", {127'd0, rdy}, 128'd0);
      step();
      chk("t5_rdy_e5", {127'd0, rdy}, 128'd1);
      chk("t5_line_wait", line_out, 128'h1234);
      preload(10'd5, 128'hBEEF);
      step();
      chk("t5_line_resp", line_out, 128'h1234);
      do_ack();
      step();

      // reset during WAIT
      issue(20'h00030);
      step(2);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("t4_rdy", {127'd0, rdy}, 128'd0);
      chk("t4_busy", {127'd0, busy}, 128'd0);
      chk("t4_line", line_out, 128'd0);
      issue(20'h00030);
      step(4);
      chk("t4_re_e4", {127'd0, rdy}, 128'd0);
      step();
      chk("t4_re_e5", {127'd0, rdy}, 128'd1);
      chk("t4_re_line", line_out, L3);
      do_ack();
      step();

      // out-of-range / wrap
      issue(20'h04000);
      step(5);
      chk("t6_rdy", {127'd0, rdy}, 128'd1);
`ifdef IMEM_BOUNDS_CHECK_EN
      chk("t6_line", line_out, 128'd0);
      chk("t6_rerr", {127'd0, range_err}, 128'd1);
      do_ack();
      chk("t6_rerr_clr", {127'd0, range_err}, 128'd0);
`else
      chk("t6_line", line_out, L0);
      do_ack();
`endif
      chk("t6_ack_rdy", {127'd0, rdy}, 128'd0);
      step();

      // LATENCY=1 with ack held high
      ack1 = 1'b1;
      req1 = 1'b1;
      addr1 = 20'h00000;
      step();
      req1 = 1'b0;
      chk("t3_rdy_e0", {127'd0, rdy1}, 128'd1);
      chk("t3_line", line_out1, L0);
`ifdef IMEM_BOUNDS_CHECK_EN
      chk("t3_rerr", {127'd0, range_err1}, 128'd0);
`endif
      step();
      chk("t3_rdy_e1", {127'd0, rdy1}, 128'd0);
      step();
      chk("t3_rdy_e2", {127'd0, rdy1}, 128'd0);
      chk("t3_busy_e2", {127'd0, busy1}, 128'd0);
      ack1 = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
